// File: rtl/mem_load_pkg.sv
// Shared state encoding, command/response byte codes and operation tags for the
// byte-stream to memory bridge.
package mem_load_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_CNT     = 4'd2,
        S_DATA    = 4'd3,
        S_WR      = 4'd4,
        S_RD_REQ  = 4'd5,
        S_RD_WAIT = 4'd6,
        S_TX      = 4'd7,
        S_FLUSH   = 4'd8,
        S_RESP    = 4'd9
    } state_t;

    typedef enum logic [1:0] {OP_W, OP_R, OP_P} op_t;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_P   = 8'h50;
    localparam logic [7:0] CMD_F   = 8'h46;

    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_TO  = 8'h54;
    localparam logic [7:0] RSP_BAD = 8'h3F;

endpackage

// File: rtl/mem_load_bridge_if.sv
// Byte-stream (rx/tx) and memory port B bundle between the bridge (master)
// and its environment (slave).
interface mem_load_bridge_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 14
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_dout,
        output rx_ready, tx_valid, tx_data, mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_dout,
        input  rx_ready, tx_valid, tx_data, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_load_ser.sv
// NB-byte shift register with byte counter: indexed byte writes assemble a
// word LSB-first, right shifts stream it out through byte0.
module mem_load_ser #(
    parameter int NB = 8,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [NB*8-1:0] load_data,
    input  logic            clr,
    input  logic            push,
    input  logic [7:0]      push_byte,
    input  logic            pop,
    output logic [NB*8-1:0] word,
    output logic [7:0]      byte0,
    output logic [CW-1:0]   cnt
);
    logic [NB*8-1:0] sr;
    logic [CW-1:0]   cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt_r <= '0;
        end else if (load) begin
            sr    <= load_data;
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (push) begin
            for (int i = 0; i < NB; i++)
                if (cnt_r == CW'(i)) sr[i*8 +: 8] <= push_byte;
            cnt_r <= cnt_r + CW'(1);
        end else if (pop) begin
            sr    <= sr >> 8;
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign word  = sr;
    assign byte0 = sr[7:0];
    assign cnt   = cnt_r;
endmodule

// File: rtl/mem_load_bridge.sv
// Byte-stream command decoder driving memory port B: burst write/read, PC peek,
// flush. Define CHECKSUM_EN to add a trailing sum byte to W and R bursts.
module mem_load_bridge
    import mem_load_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 14,
    parameter int PC_W     = 16,
    parameter int RD_LAT   = 1,
    parameter int FLUSH_TO = 4095
) (
    input  logic               clk,
    input  logic               rst,
    mem_load_bridge_if.master  bus,
    input  logic [PC_W-1:0]    cpu_pc,
    input  logic               mem_sys_fin,
    output logic               flsh,
    output logic               busy,
    output logic [3:0]         state
);
    localparam int BPW = DATA_W / 8;
    localparam int AB  = (ADDR_W + 7) / 8;
    localparam int PB  = (PC_W + 7) / 8;
    localparam int NB  = (BPW > PB) ? BPW : PB;
    localparam int SW  = NB * 8;
    localparam int CW  = $clog2(NB + 1);
    localparam int AW8 = AB * 8;
    localparam int ACW = $clog2(AB + 1);
    localparam int LW  = $clog2(RD_LAT + 1);
    localparam int FW  = $clog2(FLUSH_TO + 1);

    state_t            st;
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic [AW8-1:0]    abuf;
    logic [ACW-1:0]    acnt;
    logic [8:0]        words;
    logic [LW-1:0]     lat;
    logic [FW-1:0]     fcnt;
    logic [7:0]        rsp;
    logic [CW-1:0]     tx_last;
`ifdef CHECKSUM_EN
    logic [7:0]        sum;
    logic [7:0]        sum_rd;
    logic              ck;
`endif

    logic            rx_fire, tx_fire, rd_done, tx_end, last_word;
    logic            ser_load, ser_clr, ser_push, ser_pop;
    logic [SW-1:0]   ser_data, ser_word;
    logic [7:0]      ser_byte0;
    logic [CW-1:0]   ser_cnt;

    assign rx_fire   = bus.rx_valid && bus.rx_ready;
    assign tx_fire   = bus.tx_valid && bus.tx_ready;
    assign rd_done   = (st == S_RD_WAIT) && (lat == LW'(RD_LAT - 1));
    assign tx_end    = (st == S_TX) && tx_fire && (ser_cnt == tx_last);
    assign last_word = (words == 9'd1);

    // rx_ready is gated by rst so every output reads 0 while reset is held
    assign bus.rx_ready = !rst && (st inside {S_IDLE, S_ADDR, S_CNT, S_DATA});
    assign bus.tx_valid = (st == S_TX) || (st == S_RESP);
    assign bus.tx_data  = (st == S_RESP) ? rsp : ser_byte0;
    assign bus.mem_en   = (st == S_WR) || (st == S_RD_REQ);
    assign bus.mem_we   = (st == S_WR);
    assign bus.mem_addr = addr;
    assign bus.mem_din  = ser_word[DATA_W-1:0];
    assign flsh         = (st == S_FLUSH) && (fcnt == '0);
    assign busy         = (st != S_IDLE);
    assign state        = st;

`ifdef CHECKSUM_EN
    assign sum_rd = sum + ser_byte0;
`endif

    always_comb begin
        ser_load = 1'b0;
        ser_data = '0;
        if (st == S_IDLE && rx_fire && bus.rx_data == CMD_P) begin
            ser_load = 1'b1;
            ser_data = SW'(cpu_pc);
        end
        if (rd_done) begin
            ser_load = 1'b1;
            ser_data = SW'(bus.mem_dout);
        end
`ifdef CHECKSUM_EN
        if (tx_end && op == OP_R && !ck && last_word) begin
            ser_load = 1'b1;
            ser_data = SW'(sum_rd);
        end
        ser_push = (st == S_DATA) && rx_fire && !ck;
`else
        ser_push = (st == S_DATA) && rx_fire;
`endif
        ser_clr = ((st == S_CNT) && rx_fire) || (st == S_WR);
        ser_pop = (st == S_TX) && tx_fire;
    end

    mem_load_ser #(.NB(NB), .CW(CW)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (ser_data),
        .clr       (ser_clr),
        .push      (ser_push),
        .push_byte (bus.rx_data),
        .pop       (ser_pop),
        .word      (ser_word),
        .byte0     (ser_byte0),
        .cnt       (ser_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            op      <= OP_W;
            addr    <= '0;
            abuf    <= '0;
            acnt    <= '0;
            words   <= '0;
            lat     <= '0;
            fcnt    <= '0;
            rsp     <= '0;
            tx_last <= '0;
`ifdef CHECKSUM_EN
            sum     <= '0;
            ck      <= 1'b0;
`endif
        end else begin
            case (st)
                S_IDLE: if (rx_fire) begin
                    acnt <= '0;
                    case (bus.rx_data)
                        CMD_W: begin op <= OP_W; st <= S_ADDR; end
                        CMD_R: begin op <= OP_R; st <= S_ADDR; end
                        CMD_P: begin op <= OP_P; tx_last <= CW'(PB - 1); st <= S_TX; end
                        CMD_F: begin fcnt <= '0; st <= S_FLUSH; end
                        default: begin rsp <= RSP_BAD; st <= S_RESP; end
                    endcase
                end
                // address bytes shift in from the top so the first lands lowest
                S_ADDR: if (rx_fire) begin
                    abuf <= AW8'({bus.rx_data, abuf} >> 8);
                    acnt <= acnt + ACW'(1);
                    if (acnt == ACW'(AB - 1)) begin
                        addr <= ADDR_W'({bus.rx_data, abuf} >> 8);
                        st   <= S_CNT;
                    end
                end
                S_CNT: if (rx_fire) begin
                    words <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
`ifdef CHECKSUM_EN
                    sum   <= '0;
                    ck    <= 1'b0;
`endif
                    st    <= (op == OP_W) ? S_DATA : S_RD_REQ;
                end
                S_DATA: if (rx_fire) begin
`ifdef CHECKSUM_EN
                    if (ck) begin
                        rsp <= (bus.rx_data == sum) ? RSP_OK : RSP_ERR;
                        st  <= S_RESP;
                    end else begin
                        sum <= sum + bus.rx_data;
                        if (ser_cnt == CW'(BPW - 1)) st <= S_WR;
                    end
`else
                    if (ser_cnt == CW'(BPW - 1)) st <= S_WR;
`endif
                end
                S_WR: begin
                    addr  <= addr + 1'b1;
                    words <= words - 1'b1;
                    if (last_word) begin
`ifdef CHECKSUM_EN
                        ck  <= 1'b1;
                        st  <= S_DATA;
`else
                        rsp <= RSP_OK;
                        st  <= S_RESP;
`endif
                    end else begin
                        st <= S_DATA;
                    end
                end
                S_RD_REQ: begin
                    lat <= '0;
                    st  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (rd_done) begin
                        tx_last <= CW'(BPW - 1);
                        st      <= S_TX;
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                S_TX: begin
`ifdef CHECKSUM_EN
                    if (tx_fire && op == OP_R && !ck) sum <= sum_rd;
`endif
                    if (tx_end) begin
                        if (op != OP_R) st <= S_IDLE;
`ifdef CHECKSUM_EN
                        else if (ck) st <= S_IDLE;
`endif
                        else begin
                            addr  <= addr + 1'b1;
                            words <= words - 1'b1;
                            if (!last_word) st <= S_RD_REQ;
`ifdef CHECKSUM_EN
                            // stay in TX; the sum byte was loaded into the serialiser
                            else begin ck <= 1'b1; tx_last <= '0; end
`else
                            else st <= S_IDLE;
`endif
                        end
                    end
                end
                S_FLUSH: begin
                    if (mem_sys_fin) begin
                        rsp <= RSP_OK;
                        st  <= S_RESP;
                    end else if (fcnt == FW'(FLUSH_TO - 1)) begin
                        rsp <= RSP_TO;
                        st  <= S_RESP;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                S_RESP: if (tx_fire) st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_load_bridge.sv
// Directed bench for mem_load_bridge: W/R bursts with wrap, backpressure, PC peek,
// flush with fin and timeout, bad command, mid-command reset; CHECKSUM_EN aware.
module tb_mem_load_bridge;
    import mem_load_pkg::*;

`ifdef CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] cpu_pc;
    logic        mem_sys_fin;
    logic        flsh;
    logic        busy;
    logic [3:0]  state;

    mem_load_bridge_if #(.DATA_W(64), .ADDR_W(14)) bus ();

    mem_load_bridge #(
        .DATA_W(64), .ADDR_W(14), .PC_W(16), .RD_LAT(2), .FLUSH_TO(4095)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .cpu_pc      (cpu_pc),
        .mem_sys_fin (mem_sys_fin),
        .flsh        (flsh),
        .busy        (busy),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [13:0] wr_a[$];
    logic [63:0] wr_d[$];
    logic [13:0] rd_a[$];
    logic [7:0]  tx_q[$];
    int          en_cnt = 0;
    int          flsh_cnt = 0;
    int          first_cyc;

    // memory with a two-stage read pipe; the data is zero outside its valid cycle
    logic [63:0] d1, d2;
    function automatic logic [63:0] rd_val(input logic [13:0] a);
        return (a == 14'h0010) ? 64'hDEADBEEF01234567 : (64'h1111_0000_0000_0000 | 64'(a));
    endfunction
    always @(posedge clk) begin
        d1 <= (bus.mem_en && !bus.mem_we) ? rd_val(bus.mem_addr) : 64'h0;
        d2 <= d1;
    end
    assign bus.mem_dout = d2;

    always @(negedge clk) begin
        if (bus.mem_en) en_cnt++;
        if (bus.mem_en && bus.mem_we) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_din);
        end
        if (bus.mem_en && !bus.mem_we) rd_a.push_back(bus.mem_addr);
        if (flsh) flsh_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL rx_timeout byte %02h not accepted in 50 cycles", b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic get_tx(input int n, input int budget);
        int c = 0;
        tx_q.delete();
        first_cyc = -1;
        bus.tx_ready = 1'b1;
        while (tx_q.size() < n && c < budget) begin
            if (bus.tx_valid) begin
                if (first_cyc < 0) first_cyc = c;
                tx_q.push_back(bus.tx_data);
            end
            @(negedge clk);
            c++;
        end
        bus.tx_ready = 1'b0;
        if (tx_q.size() < n) begin
            total++;
            $display("FAIL tx_timeout got %0d bytes, required %0d", tx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({bus.rx_ready, bus.tx_valid, bus.mem_en, bus.mem_we, flsh, busy} !== 6'b0 ||
            state !== 4'd0 || bus.mem_addr !== 14'h0 || bus.mem_din !== 64'h0 || bus.tx_data !== 8'h0)
            $display("FAIL reset_outputs rdy=%b txv=%b en=%b busy=%b state=%0d, required all 0",
                     bus.rx_ready, bus.tx_valid, bus.mem_en, busy, state);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle_after_reset rdy=%b busy=%b, required 1 0", bus.rx_ready, busy);
        else passed++;
    endtask

    task automatic test_write();
        wr_a.delete(); wr_d.delete();
        send_byte(CMD_W); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        total++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1)
            $display("FAIL wr_latency en=%b we=%b after last byte, required 1 1", bus.mem_en, bus.mem_we);
        else passed++;
        if (CK != 0) send_byte(8'h88);
        get_tx(1, 50);
        total++;
        if (wr_a.size() != 2) $display("FAIL wr_count got %0d, required 2", wr_a.size());
        else passed++;
        total++;
        if (wr_a[0] !== 14'h0010 || wr_d[0] !== 64'h0807060504030201)
            $display("FAIL wr_word0 got %h/%h, required 0010/0807060504030201", wr_a[0], wr_d[0]);
        else passed++;
        total++;
        if (wr_a[1] !== 14'h0011 || wr_d[1] !== 64'h100F0E0D0C0B0A09)
            $display("FAIL wr_word1 got %h/%h, required 0011/100f0e0d0c0b0a09", wr_a[1], wr_d[1]);
        else passed++;
        total++;
        if (tx_q[0] !== RSP_OK) $display("FAIL wr_ack got %h, required 4b", tx_q[0]);
        else passed++;
    endtask

    task automatic test_write_wrap();
        wr_a.delete(); wr_d.delete();
        send_byte(CMD_W); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
        if (CK != 0) send_byte(8'h78);
        get_tx(1, 50);
        total++;
        if (wr_a.size() != 2 || wr_a[0] !== 14'h3FFF || wr_a[1] !== 14'h0000)
            $display("FAIL wrap_addr got %0d writes %h %h, required 3fff 0000", wr_a.size(), wr_a[0], wr_a[1]);
        else passed++;
        total++;
        if (wr_d[0] !== 64'hA7A6A5A4A3A2A1A0 || wr_d[1] !== 64'hAFAEADACABAAA9A8)
            $display("FAIL wrap_data got %h %h", wr_d[0], wr_d[1]);
        else passed++;
        total++;
        if (tx_q[0] !== RSP_OK) $display("FAIL wrap_ack got %h, required 4b", tx_q[0]);
        else passed++;
    endtask

    task automatic test_read_backpressure();
        logic [63:0] e = 64'hDEADBEEF01234567;
        logic [7:0]  first;
        logic        stable = 1'b1;
        int          c = 0;
        rd_a.delete();
        bus.tx_ready = 1'b0;
        send_byte(CMD_R); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
        while (!bus.tx_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        first = bus.tx_data;
        repeat (5) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== first) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1 || first !== 8'h67)
            $display("FAIL rd_hold stable=%b first=%h, required 1 67", stable, first);
        else passed++;
        get_tx(8 + CK, 100);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tx_q[i] !== e[i*8 +: 8]) $display("FAIL rd_byte%0d got %h, required %h", i, tx_q[i], e[i*8 +: 8]);
            else passed++;
        end
`ifdef CHECKSUM_EN
        total++;
        if (tx_q[8] !== 8'h08) $display("FAIL rd_sum got %h, required 08", tx_q[8]);
        else passed++;
`endif
        total++;
        if (rd_a.size() != 1 || rd_a[0] !== 14'h0010)
            $display("FAIL rd_req got %0d reads addr %h, required 1 at 0010", rd_a.size(), rd_a[0]);
        else passed++;
    endtask

    task automatic test_read_wrap();
        rd_a.delete();
        send_byte(CMD_R); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        get_tx(16 + CK, 200);
        total++;
        if (rd_a.size() != 2 || rd_a[0] !== 14'h3FFF || rd_a[1] !== 14'h0000)
            $display("FAIL rdwrap_addr got %0d reads %h %h, required 3fff 0000", rd_a.size(), rd_a[0], rd_a[1]);
        else passed++;
        total++;
        if (tx_q[0] !== 8'hFF || tx_q[1] !== 8'h3F || tx_q[8] !== 8'h00 || tx_q[15] !== 8'h11)
            $display("FAIL rdwrap_bytes got %h %h %h %h, required ff 3f 00 11", tx_q[0], tx_q[1], tx_q[8], tx_q[15]);
        else passed++;
    endtask

    task automatic test_pc();
        cpu_pc = 16'hA55A;
        send_byte(CMD_P);
        cpu_pc = 16'h0000;
        get_tx(2, 20);
        total++;
        if (tx_q[0] !== 8'h5A || tx_q[1] !== 8'hA5)
            $display("FAIL pc_bytes got %h %h, required 5a a5", tx_q[0], tx_q[1]);
        else passed++;
    endtask

    task automatic test_flush();
        flsh_cnt = 0;
        send_byte(CMD_F);
        repeat (10) @(negedge clk);
        mem_sys_fin = 1'b1;
        get_tx(1, 50);
        mem_sys_fin = 1'b0;
        total++;
        if (tx_q[0] !== RSP_OK) $display("FAIL flush_ack got %h, required 4b", tx_q[0]);
        else passed++;
        total++;
        if (flsh_cnt != 1) $display("FAIL flush_pulse got %0d pulses, required 1", flsh_cnt);
        else passed++;
    endtask

    task automatic test_flush_timeout();
        flsh_cnt = 0;
        send_byte(CMD_F);
        get_tx(1, 5000);
        total++;
        if (tx_q[0] !== RSP_TO) $display("FAIL flush_to_rsp got %h, required 54", tx_q[0]);
        else passed++;
        total++;
        if (first_cyc != 4095) $display("FAIL flush_to_time got %0d cycles, required 4095", first_cyc);
        else passed++;
        total++;
        if (flsh_cnt != 1) $display("FAIL flush_to_pulse got %0d pulses, required 1", flsh_cnt);
        else passed++;
    endtask

    task automatic test_bad_cmd();
        send_byte(8'h00);
        get_tx(1, 20);
        total++;
        if (tx_q[0] !== RSP_BAD) $display("FAIL bad_cmd got %h, required 3f", tx_q[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int en0;
        send_byte(CMD_W); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        en0 = en_cnt;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || state !== 4'd0)
            $display("FAIL mid_reset_busy busy=%b state=%0d, required 0 0", busy, state);
        else passed++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (en_cnt != en0) $display("FAIL mid_reset_en got %0d enables, required 0", en_cnt - en0);
        else passed++;
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum_bad();
        send_byte(CMD_W); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h25);
        get_tx(1, 50);
        total++;
        if (tx_q[0] !== RSP_ERR) $display("FAIL ck_bad got %h, required 45", tx_q[0]);
        else passed++;
    endtask
`endif

    initial begin
        rst          = 1'b1;
        cpu_pc       = 16'h0;
        mem_sys_fin  = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write();
        test_write_wrap();
        test_read_backpressure();
        test_read_wrap();
        test_pc();
        test_flush();
        test_flush_timeout();
        test_bad_cmd();
        test_reset_mid();
`ifdef CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end
endmodule
